// File: rtl/bus_arbiter7.sv
// bus_arbiter7: shares one 8-bit tri-state bus among requesters 1..7.
// Issues a one-hot grant that also drives the drive8 enables, and can limit
// how long one owner keeps the bus. A one-cycle idle gap always separates
// two owners, so two drivers are never enabled in the same cycle.
//
// Request/grant handshake: a[i] is a level request. The owner keeps the bus
// while a[i] stays high (and, if MAXHOLD != 0, until it has held the bus for
// MAXHOLD cycles). A request seen at an arbitration edge is granted at that
// same edge; a request that rises and falls while another owner holds the
// bus is not remembered.
module bus_arbiter7 #(
    parameter int MAXHOLD    = 8,
    parameter int ROUNDROBIN = 0
) (
    input  logic       c,
    input  logic       r,
    input  logic [7:1] a,
    output logic [7:1] g,
    output logic [7:1] e,
    output logic [2:0] y,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Counter only needs to reach MAXHOLD; one bit suffices when unlimited.
    localparam int              CW      = (MAXHOLD < 1) ? 1 : $clog2(MAXHOLD + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAXHOLD);

    logic [1:0]    state_q, state_d;
    logic [7:1]    grant_q, grant_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          busy_q,  busy_d;

    logic [7:0]    a_ext;
    logic [2:0]    win;
    logic [7:0]    win_onehot;
    logic          release_own;

    // Bit 0 padding lets the owner number (0..7) index requests directly.
    assign a_ext      = {a, 1'b0};
    assign win_onehot = 8'd1 << win;

    // Winner selection: lowest index, or first index after the last owner.
    always_comb begin
        win = 3'd0;
        if (ROUNDROBIN == 0) begin
            for (int i = 7; i >= 1; i--) begin
                if (a_ext[i]) win = 3'(i);
            end
        end else begin
            // Scan order last+1 .. last+7 (wrapping 7 -> 1); the loop runs
            // backwards so the earliest position in that order wins.
            for (int k = 7; k >= 1; k--) begin
                if (a_ext[((int'(last_q) + k - 1) % 7) + 1])
                    win = 3'(((int'(last_q) + k - 1) % 7) + 1);
            end
        end
    end

    // Owner gives up the bus when its request drops or its time is up.
    always_comb begin
        release_own = !a_ext[owner_q];
        if (MAXHOLD != 0 && cnt_q == CNT_MAX) release_own = 1'b1;
    end

    // Next-state logic for the IDLE / OWN / GAP sequence.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (a != 7'd0) begin
                    state_d = ST_OWN;
                    grant_d = win_onehot[7:1];
                    owner_d = win;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 7'd0;
                    owner_d = 3'd0;
                end
            end
            ST_OWN: begin
                if (release_own) begin
                    state_d = ST_GAP;
                    grant_d = 7'd0;
                    owner_d = 3'd0;
                    last_d  = owner_q;
                end else if (!(&cnt_q)) begin
                    // Saturating count: harmless wrap-free when unlimited.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 7'd0;
                owner_d = 3'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge c) begin
        if (!r) begin
            state_q <= ST_IDLE;
            grant_q <= 7'd0;
            owner_q <= 3'd0;
            last_q  <= 3'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign g    = grant_q;
    assign e    = grant_q;
    assign y    = owner_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter7.sv
// Bench for bus_arbiter7: four parameterisations share the request and reset
// lines; each directed phase checks one of them against hand-computed owners.
module tb_bus_arbiter7;

    logic       c = 1'b0;
    logic       r;
    logic [7:1] a;

    logic [7:1] g_w    [4];
    logic [7:1] e_w    [4];
    logic [2:0] y_w    [4];
    logic       busy_w [4];

    // Entry: {dut select[1:0], expected owner[2:0], expected busy}
    logic [5:0] exp_q[$];
    logic [5:0] m_ent;
    logic [1:0] m_sel;
    logic [2:0] m_y;
    logic       m_b;
    string      phase;
    int         checks = 0;
    int         errors = 0;
    logic       done = 1'b0;

    // clock / reset block
    always #5 c = ~c;

    bus_arbiter7 #(.MAXHOLD(8), .ROUNDROBIN(0)) u_def (
        .c(c), .r(r), .a(a), .g(g_w[0]), .e(e_w[0]), .y(y_w[0]), .busy(busy_w[0]));
    bus_arbiter7 #(.MAXHOLD(4), .ROUNDROBIN(0)) u_fix4 (
        .c(c), .r(r), .a(a), .g(g_w[1]), .e(e_w[1]), .y(y_w[1]), .busy(busy_w[1]));
    bus_arbiter7 #(.MAXHOLD(2), .ROUNDROBIN(1)) u_rr2 (
        .c(c), .r(r), .a(a), .g(g_w[2]), .e(e_w[2]), .y(y_w[2]), .busy(busy_w[2]));
    bus_arbiter7 #(.MAXHOLD(0), .ROUNDROBIN(0)) u_inf (
        .c(c), .r(r), .a(a), .g(g_w[3]), .e(e_w[3]), .y(y_w[3]), .busy(busy_w[3]));

    function automatic logic [7:1] onehot(input logic [2:0] n);
        logic [7:0] t;
        t = 8'd1 << n;
        return t[7:1];
    endfunction

    function automatic logic inv_ok(input logic [7:1] gg, input logic [7:1] ee,
                                    input logic [2:0] yy);
        if (gg !== ee) return 1'b0;
        if (yy == 3'd0) return (gg === 7'd0);
        return (gg === onehot(yy));
    endfunction

    // driver: apply inputs for one edge, then queue the expected post-edge output
    task automatic step(input logic [7:1] av, input logic rv, input logic [1:0] sel,
                        input logic [2:0] ey, input logic eb);
        a = av;
        r = rv;
        @(posedge c);
        #1;
        exp_q.push_back({sel, ey, eb});
    endtask

    task automatic reset_dut(input logic [1:0] sel);
        step(7'd0, 1'b0, sel, 3'd0, 1'b0);
    endtask

    // scoreboard monitor: invariants on every instance, queued checks on one
    always @(negedge c) begin
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!inv_ok(g_w[i], e_w[i], y_w[i])) begin
                errors++;
                $display("FAIL invariant dut%0d (%s): g=%b e=%b y=%0d", i, phase,
                         g_w[i], e_w[i], y_w[i]);
            end
        end
        if (exp_q.size() > 0) begin
            m_ent = exp_q.pop_front();
            m_sel = m_ent[5:4];
            m_y   = m_ent[3:1];
            m_b   = m_ent[0];
            checks++;
            if (y_w[m_sel] !== m_y || g_w[m_sel] !== onehot(m_y) || busy_w[m_sel] !== m_b) begin
                errors++;
                $display("FAIL %s dut%0d @%0t: got y=%0d g=%b busy=%b, want y=%0d g=%b busy=%b",
                         phase, m_sel, $time, y_w[m_sel], g_w[m_sel], busy_w[m_sel],
                         m_y, onehot(m_y), m_b);
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        r = 1'b0;
        a = 7'd0;

        phase = "reset";
        reset_dut(2'd0);
        reset_dut(2'd0);

        // Single requester 3, drop after edge 5.
        phase = "single_req3";
        for (int i = 0; i < 5; i++) step(7'b0000100, 1'b1, 2'd0, 3'd3, 1'b1);
        step(7'd0, 1'b1, 2'd0, 3'd0, 1'b1);
        step(7'd0, 1'b1, 2'd0, 3'd0, 1'b0);

        // Fixed priority with MAXHOLD=4: requesters 2,5,7.
        phase = "fixed_hold4";
        reset_dut(2'd1);
        for (int i = 0; i < 4; i++) step(7'b1010010, 1'b1, 2'd1, 3'd2, 1'b1);
        step(7'b1010010, 1'b1, 2'd1, 3'd0, 1'b1);
        step(7'b1010010, 1'b1, 2'd1, 3'd2, 1'b1);
        step(7'b1010010, 1'b1, 2'd1, 3'd2, 1'b1);
        step(7'b1010000, 1'b1, 2'd1, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) step(7'b1010000, 1'b1, 2'd1, 3'd5, 1'b1);
        step(7'b1010000, 1'b1, 2'd1, 3'd0, 1'b1);
        step(7'b1010000, 1'b1, 2'd1, 3'd5, 1'b1);

        // Round robin, MAXHOLD=2, everyone requesting.
        phase = "rr_all";
        reset_dut(2'd2);
        for (int k = 1; k <= 7; k++) begin
            step(7'h7F, 1'b1, 2'd2, 3'(k), 1'b1);
            step(7'h7F, 1'b1, 2'd2, 3'(k), 1'b1);
            step(7'h7F, 1'b1, 2'd2, 3'd0, 1'b1);
        end
        step(7'h7F, 1'b1, 2'd2, 3'd1, 1'b1);

        // Unlimited hold: requester 6 keeps the bus even when 1 asks.
        phase = "unlimited_hold";
        reset_dut(2'd3);
        for (int i = 0; i < 100; i++)
            step((i >= 20 && i < 60) ? 7'b0100001 : 7'b0100000, 1'b1, 2'd3, 3'd6, 1'b1);
        step(7'b0000001, 1'b1, 2'd3, 3'd0, 1'b1);
        step(7'b0000001, 1'b1, 2'd3, 3'd1, 1'b1);

        // Reset while requester 4 owns the bus.
        phase = "reset_mid_own";
        reset_dut(2'd0);
        step(7'b0001000, 1'b1, 2'd0, 3'd4, 1'b1);
        step(7'b0001000, 1'b1, 2'd0, 3'd4, 1'b1);
        step(7'b0001000, 1'b0, 2'd0, 3'd0, 1'b0);
        step(7'b0001000, 1'b1, 2'd0, 3'd4, 1'b1);

        // RR pointer must clear on reset: without it, 7 would follow owner 4.
        phase = "rr_reset_ptr";
        reset_dut(2'd2);
        step(7'b0001000, 1'b1, 2'd2, 3'd4, 1'b1);
        step(7'b0001000, 1'b1, 2'd2, 3'd4, 1'b1);
        step(7'b0001000, 1'b1, 2'd2, 3'd0, 1'b1);
        step(7'b0001000, 1'b1, 2'd2, 3'd4, 1'b1);
        step(7'b0001000, 1'b0, 2'd2, 3'd0, 1'b0);
        step(7'b1000001, 1'b1, 2'd2, 3'd1, 1'b1);

        // Requester 7 pulses during ownership of 1 and is never granted.
        phase = "pulse_ignored";
        reset_dut(2'd0);
        step(7'b0000001, 1'b1, 2'd0, 3'd1, 1'b1);
        step(7'b0000001, 1'b1, 2'd0, 3'd1, 1'b1);
        step(7'b1000001, 1'b1, 2'd0, 3'd1, 1'b1);
        step(7'b0000001, 1'b1, 2'd0, 3'd1, 1'b1);
        step(7'd0, 1'b1, 2'd0, 3'd0, 1'b1);
        step(7'd0, 1'b1, 2'd0, 3'd0, 1'b0);

        @(posedge c);
        done = 1'b1;
    end

endmodule
